// File: rtl/mig_pkg.sv
// Shared types and constants for the sequenced majority-inverter graph evaluator.
// An entry packs three operands {c,b,a}, and each operand is {inv, sel}.
package mig_pkg;

    localparam int NODES   = 8;
    localparam int NIN     = 7;
    localparam int OP_W    = 5;
    localparam int ENTRY_W = 15;

    // Operand select space: 0 is constant zero, then x0..x6, then node results 0..7.
    localparam logic [3:0] SEL_ZERO  = 4'd0;
    localparam logic [3:0] SEL_X0    = 4'd1;
    localparam logic [3:0] SEL_NODE0 = 4'd8;

    typedef struct packed {
        logic       inv;
        logic [3:0] sel;
    } mig_op_t;

    typedef struct packed {
        mig_op_t c;
        mig_op_t b;
        mig_op_t a;
    } mig_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_FIN
    } state_t;

endpackage

// File: rtl/mig_seq_evaluator_maj3_cell.sv
// Combinational three-input majority with an optional inversion on each input.
module maj3_cell (
    input  logic [2:0] opnd,
    input  logic [2:0] inv,
    output logic       maj
);

    logic [2:0] v;

    assign v   = opnd ^ inv;
    assign maj = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);

endmodule

// File: rtl/mig_seq_evaluator.sv
// Time-multiplexed majority-inverter graph evaluator. It holds a small program of
// majority nodes and evaluates one node per cycle on a single shared MAJ3 cell.
module mig_seq_evaluator
    import mig_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [2:0]          cfg_addr,
    input  logic [ENTRY_W-1:0]  cfg_data,
    input  logic [3:0]          cfg_len,
    input  logic                cfg_out_inv,
    input  logic                start,
    input  logic [NIN-1:0]      x_in,
    output logic                busy,
    output logic                done,
    output logic                out,
    output logic                err
);

    state_t             state_reg, state_next;
    mig_entry_t         prog_mem [NODES];
    logic [NODES-1:0]   node_reg;
    logic [NIN-1:0]     x_reg;
    logic [3:0]         len_reg;
    logic [2:0]         k_reg;
    logic               out_inv_reg;
    logic               bad_len_reg;
    logic               busy_reg, done_reg, out_reg, err_reg;

    logic [ENTRY_W-1:0] cur_bits;
    logic [2:0]         opnd_raw, opnd_inv, opnd_fwd;
    logic               maj_y;
    logic               len_ok;
    logic               last_node;

    assign cur_bits  = prog_mem[k_reg];
    assign len_ok    = (cfg_len != 4'd0) && (cfg_len <= 4'(NODES));
    assign last_node = ({1'b0, k_reg} == (len_reg - 4'd1));

    // Operand muxes. A node reference at or beyond the node being evaluated has
    // no valid value yet, so it reads as zero and flags the run as faulty.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_opnd
            mig_op_t op;
            logic    raw, fwd;

            assign op = mig_op_t'(cur_bits[gi*OP_W +: OP_W]);

            always_comb begin
                raw = 1'b0;
                fwd = 1'b0;
                if (op.sel >= SEL_NODE0) begin
                    if (op.sel[2:0] >= k_reg) begin
                        fwd = 1'b1;
                    end else begin
                        raw = node_reg[op.sel[2:0]];
                    end
                end else if (op.sel != SEL_ZERO) begin
                    raw = x_reg[op.sel[2:0] - SEL_X0[2:0]];
                end
            end

            assign opnd_raw[gi] = raw;
            assign opnd_fwd[gi] = fwd;
            assign opnd_inv[gi] = op.inv;
        end
    endgenerate

    maj3_cell u_maj3 (
        .opnd (opnd_raw),
        .inv  (opnd_inv),
        .maj  (maj_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = len_ok ? ST_EVAL : ST_FIN;
                end
            end
            ST_EVAL: begin
                if (last_node) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NODES; i++) begin
                prog_mem[i] <= '0;
            end
            node_reg    <= '0;
            x_reg       <= '0;
            len_reg     <= '0;
            k_reg       <= '0;
            out_inv_reg <= 1'b0;
            bad_len_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            out_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            // The program is frozen for the whole run, including FIN.
            if (cfg_we && state_reg == ST_IDLE) begin
                prog_mem[cfg_addr] <= mig_entry_t'(cfg_data);
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        x_reg       <= x_in;
                        len_reg     <= cfg_len;
                        out_inv_reg <= cfg_out_inv;
                        k_reg       <= 3'd0;
                        busy_reg    <= 1'b1;
                        err_reg     <= !len_ok;
                        bad_len_reg <= !len_ok;
                    end
                end
                ST_EVAL: begin
                    node_reg[k_reg] <= maj_y;
                    k_reg           <= k_reg + 3'd1;
                    if (|opnd_fwd) begin
                        err_reg <= 1'b1;
                    end
                end
                ST_FIN: begin
                    out_reg  <= bad_len_reg ? out_inv_reg
                                            : (node_reg[len_reg[2:0] - 3'd1] ^ out_inv_reg);
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign out  = out_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_mig_seq_evaluator.sv
// Self-checking bench: a fixed table of chain-program runs, hand sequences for the
// multi-cycle corner cases, and random programs checked against a graph-level model.
module tb_mig_seq_evaluator;

    logic        clk = 1'b0;
    logic        rst_n, cfg_we, cfg_out_inv, start;
    logic [2:0]  cfg_addr;
    logic [14:0] cfg_data;
    logic [3:0]  cfg_len;
    logic [6:0]  x_in;
    logic        busy, done, out, err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0] m_prog [8];
    logic [14:0] chain  [5];

    typedef struct {
        logic [6:0] x;
        int         len;
        bit         oinv;
        bit         eo;
        bit         ee;
        int         lat;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    mig_seq_evaluator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_len     (cfg_len),
        .cfg_out_inv (cfg_out_inv),
        .start       (start),
        .x_in        (x_in),
        .busy        (busy),
        .done        (done),
        .out         (out),
        .err         (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [14:0] mk(input int a, input int b, input int c);
        logic [4:0] fa, fb, fc;
        fa = a[4:0];
        fb = b[4:0];
        fc = c[4:0];
        return {fc, fb, fa};
    endfunction

    // Graph-level reference: operands resolve to constants, inputs or earlier
    // node values; a vote of two or more makes the node true.
    function automatic void model(input logic [6:0] x, input int len, input bit oinv,
                                  output bit mo, output bit me, output int lat);
        bit         nv [8];
        int         votes, s;
        bit         v;
        logic [4:0] op;
        mo  = oinv;
        me  = 1'b1;
        lat = 1;
        if (len < 1 || len > 8) return;
        me  = 1'b0;
        lat = len + 1;
        for (int k = 0; k < len; k++) begin
            votes = 0;
            for (int j = 0; j < 3; j++) begin
                op = m_prog[k][j*5 +: 5];
                s  = int'(op[3:0]);
                if (s == 0)          v = 1'b0;
                else if (s < 8)      v = x[s-1];
                else if (s - 8 < k)  v = nv[s-8];
                else begin
                    v  = 1'b0;
                    me = 1'b1;
                end
                if (v ^ op[4]) votes++;
            end
            nv[k] = (votes >= 2);
        end
        mo = nv[len-1] ^ oinv;
    endfunction

    task automatic write_entry(input int addr, input logic [14:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr[2:0];
        cfg_data = data;
        tick;
        cfg_we   = 1'b0;
        m_prog[addr] = data;
    endtask

    task automatic load_chain;
        for (int i = 0; i < 5; i++) write_entry(i, chain[i]);
    endtask

    task automatic wait_done(input string name, inout int cnt);
        while (done !== 1'b1 && cnt < 30) begin
            tick;
            cnt++;
        end
        if (cnt >= 30) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic run(input string name, input logic [6:0] x, input int len, input bit oinv,
                       input bit eo, input bit ee, input int elat);
        int cnt = 0;
        x_in = x;
        cfg_len = len[3:0];
        cfg_out_inv = oinv;
        start = 1'b1;
        tick;
        start = 1'b0;
        x_in = ~x;
        cfg_out_inv = ~oinv;
        if (elat > 1) check({name, "_busy"}, busy, 1);
        wait_done(name, cnt);
        check({name, "_lat"}, cnt, elat);
        check({name, "_out"}, out, eo);
        check({name, "_err"}, err, ee);
        tick;
        check({name, "_pulse"}, done, 0);
        check({name, "_idle"}, busy, 0);
        $display("run %s x=%h len=%0d inv=%0d -> out=%0d err=%0d lat=%0d", name, x, len, oinv, out, err, cnt);
    endtask

    task automatic run_model(input string name, input logic [6:0] x, input int len, input bit oinv);
        bit mo, me;
        int lat;
        model(x, len, oinv, mo, me, lat);
        run(name, x, len, oinv, mo, me, lat);
    endtask

    initial begin
        int cnt;
        chain[0] = mk(1, 6, 7);
        chain[1] = mk(1, 4, 5);
        chain[2] = mk(1, 2, 8);
        chain[3] = mk(1, 9, 10);
        chain[4] = mk(1, 3, 11);

        tbl[0]  = '{7'h7F, 5, 1'b0, 1'b1, 1'b0, 6};
        tbl[1]  = '{7'h01, 5, 1'b0, 1'b0, 1'b0, 6};
        tbl[2]  = '{7'h05, 5, 1'b0, 1'b1, 1'b0, 6};
        tbl[3]  = '{7'h01, 5, 1'b1, 1'b1, 1'b0, 6};
        tbl[4]  = '{7'h78, 5, 1'b0, 1'b0, 1'b0, 6};
        tbl[5]  = '{7'h7E, 5, 1'b0, 1'b1, 1'b0, 6};
        tbl[6]  = '{7'h7F, 3, 1'b0, 1'b1, 1'b0, 4};
        tbl[7]  = '{7'h01, 1, 1'b1, 1'b1, 1'b0, 2};
        tbl[8]  = '{7'h00, 0, 1'b1, 1'b1, 1'b1, 1};
        tbl[9]  = '{7'h00, 0, 1'b0, 1'b0, 1'b1, 1};
        tbl[10] = '{7'h7F, 9, 1'b0, 1'b0, 1'b1, 1};

        for (int i = 0; i < 8; i++) m_prog[i] = '0;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        cfg_len = '0; cfg_out_inv = 1'b0; start = 1'b0; x_in = '0;
        tick;
        tick;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out", out, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick;

        load_chain();
        for (int i = 0; i < 11; i++) begin
            run($sformatf("tbl%0d", i), tbl[i].x, tbl[i].len, tbl[i].oinv,
                tbl[i].eo, tbl[i].ee, tbl[i].lat);
        end

        // Forward reference in node 0, then a clean run clears the flag.
        write_entry(0, mk(9, 1, 2));
        run_model("fwd", 7'h7F, 2, 1'b0);
        check("fwd_flag", err, 1);
        write_entry(0, chain[0]);
        run("fwd_clean", 7'h7F, 5, 1'b0, 1'b1, 1'b0, 6);

        // Write and start in the same idle cycle: node 4 becomes MAJ(x2,x2,0)=x2.
        cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = mk(3, 3, 0);
        x_in = 7'h7B; cfg_len = 4'd5; cfg_out_inv = 1'b0; start = 1'b1;
        tick;
        cfg_we = 1'b0; start = 1'b0;
        cnt = 0;
        wait_done("same_cycle", cnt);
        check("same_cycle_out", out, 0);
        write_entry(4, chain[4]);

        // Start and write attempted mid-run are ignored.
        x_in = 7'h7F; cfg_len = 4'd5; cfg_out_inv = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        cnt = 0;
        tick; cnt++;
        tick; cnt++;
        cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = '0; start = 1'b1; x_in = 7'h00;
        tick; cnt++;
        cfg_we = 1'b0; start = 1'b0;
        wait_done("midrun", cnt);
        check("midrun_lat", cnt, 6);
        check("midrun_out", out, 1);
        tick;
        check("midrun_restart", busy, 0);
        run("midrun_prog", 7'h05, 5, 1'b0, 1'b1, 1'b0, 6);

        // Reset in the middle of evaluation.
        x_in = 7'h7F; cfg_len = 4'd5; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_out", out, 0);
        check("abort_err", err, 0);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m_prog[i] = '0;
        tick;
        run("after_rst1", 7'h7F, 1, 1'b0, 1'b0, 1'b0, 2);
        run("after_rst5", 7'h7F, 5, 1'b0, 1'b0, 1'b0, 6);

        // Random programs against the reference model.
        for (int it = 0; it < 40; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                write_entry($urandom_range(0, 7), 15'($urandom));
            end
            run_model($sformatf("rnd%0d", it), 7'($urandom), $urandom_range(0, 10), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
